// File: rtl/sd_host_pkg.sv
// rtl/sd_host_pkg.sv - shared constants, state encoding and byte helpers for the SD image host
// Purpose: command codes on the SD byte-command link, host FSM states, sector size
//          and small helpers used by sd_img_host.
// Ports:   none (package).
package sd_host_pkg;

  localparam logic [7:0] SD_CMD_STATUS   = 8'h01;
  localparam logic [7:0] SD_CMD_CORE_RW  = 8'h02;
  localparam logic [7:0] SD_CMD_INSERTED = 8'h04;

  // 512-byte sectors
  localparam int SECTOR_SHIFT = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MOUNT   = 3'd1,
    ST_STAT    = 3'd2,
    ST_XLATE   = 3'd3,
    ST_RW_CMD  = 3'd4,
    ST_RW_POLL = 3'd5,
    ST_DONE    = 3'd6
  } host_state_e;

  // Big-endian byte pick: k=0 is bits [31:24], k=3 is bits [7:0].
  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // Lowest set bit of a request bitmap; callers only use it for a non-zero bitmap.
  function automatic logic [1:0] lowest_slot(input logic [3:0] bm);
    if (bm[0]) return 2'd0;
    if (bm[1]) return 2'd1;
    if (bm[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/sd_host_byte_if.sv
// rtl/sd_host_byte_if.sv - single byte operation on the SD byte-command link
// Purpose: on go, drives strobe for one cycle together with start/tx, then waits
//          STROBE_GAP cycles and presents the response on the last wait cycle.
// Ports:   clk, reset      - clock, synchronous active-high reset
//          go, start, tx   - request a byte op (accepted only when idle)
//          strobe          - link data_strobe
//          sd_start, sd_tx - link data_start / data_in, valid only with strobe
//          sd_rx           - link data_out
//          rx, rdy         - response byte, valid while rdy is high (one cycle)
module sd_host_byte_if #(
  parameter int STROBE_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       start,
  input  logic [7:0] tx,
  output logic       strobe,
  output logic       sd_start,
  output logic [7:0] sd_tx,
  input  logic [7:0] sd_rx,
  output logic [7:0] rx,
  output logic       rdy
);

  localparam int CW = $clog2(STROBE_GAP + 1);

  logic          strobe_q;
  logic          start_q;
  logic [7:0]    tx_q;
  logic [CW-1:0] cnt_q;

  // cnt_q holds the remaining wait cycles after the strobe cycle; zero with no
  // strobe pending means idle, so a new go cannot overlap a running op.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= 1'b0;
      start_q  <= 1'b0;
      tx_q     <= 8'h00;
      cnt_q    <= '0;
    end else if (strobe_q) begin
      strobe_q <= 1'b0;
      start_q  <= 1'b0;
      tx_q     <= 8'h00;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end else if (go) begin
      strobe_q <= 1'b1;
      start_q  <= start;
      tx_q     <= tx;
      cnt_q    <= CW'(STROBE_GAP);
    end
  end

  assign strobe   = strobe_q;
  assign sd_start = start_q;
  assign sd_tx    = tx_q;
  assign rdy      = !strobe_q && (cnt_q == CW'(1));
  assign rx       = sd_rx;

endmodule

// File: rtl/sd_img_host.sv
// rtl/sd_img_host.sv - MCU stand-in that serves sd_card image sector requests
// Purpose: announces mounted images (INSERTED), and on irq reads STATUS, maps the
//          requested image sector to a physical LBA through a 4-slot base/size
//          table, issues CORE_RW and polls it to completion.
// Ports:   clk, reset                         - clock, synchronous active-high reset
//          cfg_we/cfg_idx/cfg_lba/cfg_size   - slot table write
//          mount_req                          - send INSERTED for slot cfg_idx
//          sd_strobe/sd_start/sd_tx/sd_rx     - byte-command link
//          sd_irq/sd_iack                     - request interrupt and acknowledge
//          busy/req_done/err                  - status
// Option:  SD_HOST_TIMEOUT_EN adds parameter POLL_MAX and aborts RW_POLL with err
//          after POLL_MAX busy polls.
module sd_img_host
  import sd_host_pkg::*;
#(
  parameter int STROBE_GAP = 2
`ifdef SD_HOST_TIMEOUT_EN
  , parameter int POLL_MAX = 65535
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_idx,
  input  logic [31:0] cfg_lba,
  input  logic [31:0] cfg_size,
  input  logic        mount_req,
  output logic        sd_strobe,
  output logic        sd_start,
  output logic [7:0]  sd_tx,
  input  logic [7:0]  sd_rx,
  input  logic        sd_irq,
  output logic        sd_iack,
  output logic        busy,
  output logic        req_done,
  output logic        err
);

  host_state_e state_q, state_d;

  logic [31:0] base_q [4];
  logic [31:0] size_q [4];

  logic        irq_q, iack_q, irq_pend_q, mnt_pend_q;
  logic [1:0]  mnt_slot_q, cur_slot_q;
  logic        op_pend_q;
  logic [2:0]  idx_q;
  logic [3:0]  bitmap_q;
  logic [31:0] rsector_q;
  logic [31:0] lba_q;

  logic        bi_go, bi_start, bi_rdy;
  logic [7:0]  bi_tx, bi_rx;
  logic [2:0]  last_idx;
  logic        op_last;
  logic        irq_rise, mnt_take, stat_enter;
  logic        timeout_hit;

  logic [1:0]  x_slot;
  logic [31:0] x_nsec, x_lba;
  logic        x_in_range;

  sd_host_byte_if #(.STROBE_GAP(STROBE_GAP)) u_byte_if (
    .clk      (clk),
    .reset    (reset),
    .go       (bi_go),
    .start    (bi_start),
    .tx       (bi_tx),
    .strobe   (sd_strobe),
    .sd_start (sd_start),
    .sd_tx    (sd_tx),
    .sd_rx    (sd_rx),
    .rx       (bi_rx),
    .rdy      (bi_rdy)
  );

  // Slot table
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        base_q[k] <= '0;
        size_q[k] <= '0;
      end
    end else if (cfg_we) begin
      base_q[cfg_idx] <= cfg_lba;
      size_q[cfg_idx] <= cfg_size;
    end
  end

  // Pending requests. Flags clear on entry to their service state so a new
  // event arriving during service is kept for another pass; a set in the
  // same cycle as the clear wins.
  assign irq_rise   = sd_irq && !irq_q;
  assign mnt_take   = (state_q == ST_IDLE) && (state_d == ST_MOUNT);
  assign stat_enter = (state_q != ST_STAT) && (state_d == ST_STAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q      <= 1'b0;
      iack_q     <= 1'b0;
      irq_pend_q <= 1'b0;
      mnt_pend_q <= 1'b0;
      mnt_slot_q <= 2'd0;
      cur_slot_q <= 2'd0;
    end else begin
      irq_q  <= sd_irq;
      iack_q <= irq_rise;
      if (irq_rise)        irq_pend_q <= 1'b1;
      else if (stat_enter) irq_pend_q <= 1'b0;
      if (mount_req) begin
        mnt_pend_q <= 1'b1;
        mnt_slot_q <= cfg_idx;
      end else if (mnt_take) begin
        mnt_pend_q <= 1'b0;
      end
      // MOUNT sends from its own copy so a later mount_req cannot alter it
      if (mnt_take) cur_slot_q <= mnt_slot_q;
    end
  end

  // Index of the final byte op in each sequencing state
  always_comb begin
    last_idx = 3'd0;
    case (state_q)
      ST_MOUNT:  last_idx = 3'd5;
      ST_STAT:   last_idx = 3'd5;
      ST_RW_CMD: last_idx = 3'd4;
      default:   last_idx = 3'd0;
    endcase
  end

  assign op_last = bi_rdy && (idx_q == last_idx);

  // Sector translation for the lowest pending slot
  always_comb begin
    x_slot     = lowest_slot(bitmap_q);
    x_nsec     = size_q[x_slot] >> SECTOR_SHIFT;
    x_in_range = rsector_q < x_nsec;
    if (x_in_range)
      x_lba = base_q[x_slot] + rsector_q;
    else if (x_nsec != '0)
      x_lba = base_q[x_slot] + x_nsec - 32'd1;
    else
      x_lba = base_q[x_slot];
  end

  // Byte sequencing and response capture. Only one op is outstanding:
  // op_pend_q blocks go until the matching rdy.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_pend_q <= 1'b0;
      idx_q     <= 3'd0;
      bitmap_q  <= 4'h0;
      rsector_q <= '0;
      lba_q     <= '0;
    end else begin
      if (bi_go)       op_pend_q <= 1'b1;
      else if (bi_rdy) op_pend_q <= 1'b0;
      if (bi_rdy) idx_q <= (idx_q == last_idx) ? 3'd0 : idx_q + 3'd1;
      // STATUS responses: op 1 carries the bitmap, ops 2..5 rsector MSB first
      if (state_q == ST_STAT && bi_rdy) begin
        if (idx_q == 3'd1) bitmap_q <= bi_rx[3:0];
        else if (idx_q >= 3'd2) rsector_q <= {rsector_q[23:0], bi_rx};
      end
      if (state_q == ST_XLATE) lba_q <= x_lba;
    end
  end

`ifdef SD_HOST_TIMEOUT_EN
  logic [31:0] poll_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != ST_RW_POLL) poll_cnt_q <= '0;
    else if (bi_rdy)                    poll_cnt_q <= poll_cnt_q + 32'd1;
  end

  // Fires on the busy response of the POLL_MAX-th poll
  assign timeout_hit = (state_q == ST_RW_POLL) && bi_rdy && bi_rx[0] &&
                       (poll_cnt_q == 32'(POLL_MAX - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mnt_pend_q)      state_d = ST_MOUNT;
        else if (irq_pend_q) state_d = ST_STAT;
      end
      ST_MOUNT:  if (op_last) state_d = ST_IDLE;
      ST_STAT:   if (op_last) state_d = (bitmap_q == 4'h0) ? ST_IDLE : ST_XLATE;
      ST_XLATE:  state_d = ST_RW_CMD;
      ST_RW_CMD: if (op_last) state_d = ST_RW_POLL;
      ST_RW_POLL: begin
        if (bi_rdy) begin
          if (!bi_rx[0])        state_d = ST_DONE;
          else if (timeout_hit) state_d = ST_IDLE;
        end
      end
      // Re-read STATUS: requests queued without a new irq edge are found here
      ST_DONE:   state_d = ST_STAT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bi_go    = 1'b0;
    bi_start = 1'b0;
    bi_tx    = 8'h00;
    req_done = 1'b0;
    err      = 1'b0;
    case (state_q)
      ST_MOUNT: begin
        bi_go    = !op_pend_q;
        bi_start = (idx_q == 3'd0);
        if (idx_q == 3'd0)      bi_tx = SD_CMD_INSERTED;
        else if (idx_q == 3'd1) bi_tx = {6'd0, cur_slot_q};
        else                    bi_tx = be_byte(size_q[cur_slot_q], 2'(idx_q - 3'd2));
      end
      ST_STAT: begin
        bi_go    = !op_pend_q;
        bi_start = (idx_q == 3'd0);
        bi_tx    = (idx_q == 3'd0) ? SD_CMD_STATUS : 8'h00;
      end
      ST_XLATE: err = !x_in_range;
      ST_RW_CMD: begin
        bi_go    = !op_pend_q;
        bi_start = (idx_q == 3'd0);
        bi_tx    = (idx_q == 3'd0) ? SD_CMD_CORE_RW : be_byte(lba_q, 2'(idx_q - 3'd1));
      end
      ST_RW_POLL: begin
        bi_go = !op_pend_q;
        err   = timeout_hit;
      end
      ST_DONE: req_done = 1'b1;
      default: ;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign sd_iack = iack_q;

endmodule
